// File: rtl/led_fade.sv
// Eight-channel LED afterglow: each channel loads to full brightness on an input
// pulse, decays in fixed steps on a slow timer, and is PWM-driven from its level.
module led_fade #(
   parameter int unsigned DECAY_COUNT = 250000,
   parameter int unsigned DECAY_STEP  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fadeEn,
   input  logic [7:0] dataIn,
   output logic [7:0] ledOut
);

   localparam int unsigned   TW         = (DECAY_COUNT > 1) ? $clog2(DECAY_COUNT) : 1;
   localparam logic [TW-1:0] DECAY_LAST = TW'(DECAY_COUNT - 1);
   localparam logic [7:0]    STEP       = 8'(DECAY_STEP);
   localparam logic [7:0]    PWM_LAST   = 8'd254;

   logic [7:0][7:0] level_q, level_d;
   logic [7:0]      pwm_cnt_q, pwm_cnt_d;
   logic [TW-1:0]   decay_cnt_q, decay_cnt_d;
   logic [7:0]      led_q, led_d;
   logic            decay_tick;

   always_comb begin
      decay_tick  = (decay_cnt_q == DECAY_LAST);
      decay_cnt_d = decay_tick ? '0 : decay_cnt_q + TW'(1);
      pwm_cnt_d   = (pwm_cnt_q == PWM_LAST) ? 8'd0 : pwm_cnt_q + 8'd1;
      level_d     = level_q;
      led_d       = '0;
      for (int i = 0; i < 8; i++) begin
         // Level 255 beats every pwm value (max 254), so a full channel never blinks.
         led_d[i] = (level_q[i] > pwm_cnt_q);
         if (!fadeEn) begin
            level_d[i] = {8{dataIn[i]}};
         end else if (dataIn[i]) begin
            level_d[i] = 8'hFF;
         end else if (decay_tick) begin
            level_d[i] = (level_q[i] > STEP) ? (level_q[i] - STEP) : 8'h00;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         level_q     <= '0;
         pwm_cnt_q   <= '0;
         decay_cnt_q <= '0;
         led_q       <= '0;
      end else begin
         level_q     <= level_d;
         pwm_cnt_q   <= pwm_cnt_d;
         decay_cnt_q <= decay_cnt_d;
         led_q       <= led_d;
      end
   end

   assign ledOut = led_q;

endmodule

// File: tb/tb_led_fade.sv
// Randomised and directed bench for led_fade; a cycle-count based reference model
// predicts every channel level and the LED outputs.
module tb_led_fade;

   localparam int DC      = 4;
   localparam int DS      = 64;
   localparam int SLOW_DC = 1000;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       fade_en = 1'b0;
   logic [7:0] din = 8'h00;
   logic [7:0] led;
   logic [7:0] slow_din = 8'h00;
   logic [7:0] slow_led;

   always #5 clk = ~clk;

   led_fade #(.DECAY_COUNT(DC), .DECAY_STEP(DS)) dut (
      .clk    (clk),
      .rst    (rst),
      .fadeEn (fade_en),
      .dataIn (din),
      .ledOut (led)
   );

   // Long decay period so a level can be held steady across a full PWM period.
   led_fade #(.DECAY_COUNT(SLOW_DC), .DECAY_STEP(DS)) dut_slow (
      .clk    (clk),
      .rst    (rst),
      .fadeEn (fade_en),
      .dataIn (slow_din),
      .ledOut (slow_led)
   );

   int         n_checks = 0;
   int         n_errors = 0;
   int         lvl_m[8];
   int         cyc_m = 0;
   logic [7:0] exp_led = 8'h00;
   logic [7:0] exp_q[$];
   logic [7:0] seen_q[$];

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model_levels();
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < 8; i++) v[i*8 +: 8] = 8'(lvl_m[i]);
      return v;
   endfunction

   // Model: pwm = cycles since reset mod 255, decay tick when cycles mod DC == DC-1.
   task automatic step();
      logic tick;
      @(posedge clk);
      if (!rst) begin
         for (int i = 0; i < 8; i++) lvl_m[i] = 0;
         cyc_m   = 0;
         exp_led = 8'h00;
      end else begin
         tick = ((cyc_m % DC) == DC - 1);
         for (int i = 0; i < 8; i++) exp_led[i] = (lvl_m[i] > (cyc_m % 255));
         for (int i = 0; i < 8; i++) begin
            if (!fade_en)   lvl_m[i] = din[i] ? 255 : 0;
            else if (din[i]) lvl_m[i] = 255;
            else if (tick)  lvl_m[i] = (lvl_m[i] > DS) ? lvl_m[i] - DS : 0;
         end
         cyc_m++;
      end
      #1;
      check_val("led_out", led, exp_led);
      check_val("levels", dut.level_q, model_levels());
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int found;
      int highs;
      int pre;
      int prev;
      int lvl;
      int t1;
      int t2;
      logic ok;

      for (int i = 0; i < 8; i++) lvl_m[i] = 0;

      // Reset held for three edges.
      rst = 1'b0;
      repeat (3) begin
         step();
         check_val("reset_led", led, 64'h0);
         check_val("reset_pwm", dut.pwm_cnt_q, 64'h0);
      end

      // Pass-through.
      rst = 1'b1; fade_en = 1'b0; din = 8'h81;
      step();
      check_val("pass_first", led, 64'h00);
      step();
      check_val("pass_led", led, 64'h81);
      step();
      check_val("pass_hold", led, 64'h81);

      // Decay sequence on channel 0.
      fade_en = 1'b1; din = 8'h00;
      repeat (20) step();
      din = 8'h01;
      step();
      din = 8'h00;
      seen_q.push_back(dut.level_q[0]);
      repeat (24) begin
         step();
         if (dut.level_q[0] != seen_q[$]) seen_q.push_back(dut.level_q[0]);
      end
      exp_q = '{8'd255, 8'd191, 8'd127, 8'd63, 8'd0};
      check_val("decay_len", seen_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++)
         check_val("decay_seq", seen_q[i], exp_q[i]);
      check_val("decay_floor", dut.level_q[0], 64'h0);

      // Load beats decay on channel 3.
      din = 8'h08;
      step();
      din = 8'h00;
      found = 0;
      for (int k = 0; k < 40; k++) begin
         if (lvl_m[3] == 127 && (cyc_m % DC) == DC - 1) begin
            found = 1;
            break;
         end
         step();
      end
      check_val("load_wait", found, 1);
      if (found == 1) begin
         check_val("load_pre", dut.level_q[3], 64'd127);
         din = 8'h08;
         step();
         check_val("load_wins", dut.level_q[3], 64'd255);
         din = 8'h00;
      end

      // Rotating dot.
      for (int k = 0; k < 8; k++) begin
         din = 8'h80 >> k;
         repeat (8) step();
         check_val("rot_cur", dut.level_q[7-k], 64'd255);
         prev = 255;
         for (int j = 8 - k; j < 8; j++) begin
            lvl = int'(dut.level_q[j]);
            ok  = (lvl == 0) ? 1'b1 : (lvl < prev);
            check_val("rot_order", ok, 64'd1);
            prev = lvl;
         end
      end
      din = 8'h00;

      // Random traffic with occasional fade mode changes.
      for (int k = 0; k < 300; k++) begin
         din = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
         if ($urandom_range(0, 39) == 0) fade_en = ~fade_en;
         step();
      end

      // Duty measurement at level 191 on the slow instance.
      fade_en = 1'b1; din = 8'h00;
      slow_din = 8'h01;
      step();
      slow_din = 8'h00;
      found = 0;
      for (int k = 0; k < SLOW_DC + 100; k++) begin
         step();
         if (dut_slow.level_q[0] == 8'd191) begin
            found = 1;
            break;
         end
      end
      check_val("duty_wait", found, 1);
      highs = 0;
      for (int k = 0; k < 255; k++) begin
         pre = cyc_m % 255;
         step();
         highs += int'(slow_led[0]);
         check_val("duty_bit", slow_led[0], (191 > pre) ? 64'd1 : 64'd0);
      end
      check_val("duty_count", highs, 191);

      // Reset in the middle of a fade with pwm at 100.
      din = 8'h00;
      found = 0;
      for (int k = 0; k < 600 && found == 0; k++) begin
         t1 = cyc_m + 1 + ((DC - 1 - ((cyc_m + 1) % DC)) % DC);
         t2 = t1 + DC;
         for (int s = t2 + 1; s <= t2 + DC; s++) if (s % 255 == 100) found = 1;
         if (found == 1) begin
            din = 8'h20;
            step();
            din = 8'h00;
         end else begin
            step();
         end
      end
      check_val("mid_search", found, 1);
      found = 0;
      for (int k = 0; k < 20; k++) begin
         if (cyc_m % 255 == 100) begin
            found = 1;
            break;
         end
         step();
      end
      check_val("mid_wait", found, 1);
      check_val("mid_level", dut.level_q[5], 64'd127);
      check_val("mid_pwm", dut.pwm_cnt_q, 64'd100);
      rst = 1'b0;
      step();
      check_val("rst_levels", dut.level_q, 64'h0);
      check_val("rst_pwm", dut.pwm_cnt_q, 64'h0);
      check_val("rst_timer", dut.decay_cnt_q, 64'h0);
      check_val("rst_led", led, 64'h0);
      rst = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         check_val("restart_pwm", dut.pwm_cnt_q, 64'(k));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/led_fade.md
LED_FADE -- requirements
Module: led_fade

Interface
REQ-001 Parameter DECAY_COUNT, default 250000, is the number of clk cycles between decay steps (range 1 to 2^22).
REQ-002 Parameter DECAY_STEP, default 16, is the brightness amount removed per decay step (range 1 to 255).
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on the rising edge.
REQ-004 Port rst  input  1  is the reset: synchronous, active-low (0 = reset), sampled on the clk rising edge.
REQ-005 Port fadeEn  input  1  SHALL enable afterglow when 1 and select plain on/off pass-through when 0.
REQ-006 Port dataIn  input  8  is the LED pattern from the upstream rotating-dot stage; bit i drives channel i.
REQ-007 Port ledOut  output  8  is the registered PWM drive to the board LEDs, active-high.

Function
REQ-008 The block SHALL hold eight 8-bit brightness registers, level[0..7].
REQ-009 The PWM counter pwmCnt SHALL be 8 bits and count 0,1,...,254, then wrap to 0, giving a 255-cycle period.
REQ-010 The decay timer SHALL count 0 to DECAY_COUNT-1 and then wrap to 0; the cycle it equals DECAY_COUNT-1 is a decay tick.
REQ-011 When fadeEn=1 and dataIn[i]=1 in a cycle, level[i] SHALL be 255 on the next cycle.
REQ-012 When fadeEn=1, dataIn[i]=0 and it is a decay tick, level[i] SHALL become max(level[i]-DECAY_STEP, 0) (saturating, no wrap).
REQ-013 When fadeEn=1, dataIn[i]=0 and it is not a decay tick, level[i] SHALL hold its value.
REQ-014 If dataIn[i]=1 on a decay tick, the load to 255 SHALL win over the decay.
REQ-015 When fadeEn=0, level[i] SHALL be 255 when dataIn[i]=1 and 0 when dataIn[i]=0, updated every cycle.
REQ-016 The decay timer and pwmCnt SHALL run continuously regardless of fadeEn.
REQ-017 ledOut[i] SHALL be registered as (level[i] > pwmCnt), using the current level and pwmCnt values.
- Level 0: channel never on.
- Level 255: channel always on.
- Level L: channel on for exactly L of every 255 cycles.
REQ-018 Latency SHALL be exactly 2 cycles: a dataIn[i] rise sampled at edge n gives level[i]=255 after edge n, and ledOut[i]=1 after edge n+1.
REQ-019 All eight channels SHALL be independent; any number of dataIn bits may be set at the same time.
REQ-020 A change of fadeEn SHALL take effect on the next edge without glitching any counter.

Reset
REQ-021 While rst=0 at a clk edge, the following SHALL all become 0 on that edge:
- level[0..7]
- pwmCnt
- the decay timer
- ledOut
REQ-022 Reset SHALL override all other activity, including in the middle of a fade or a PWM period.
REQ-023 On the first edge with rst=1, normal operation SHALL begin from the zero state (pwmCnt counts 0,1,...).
REQ-024 There SHALL be no asynchronous behaviour; rst changing between edges SHALL have no effect.

Verification (bench parameters: DECAY_COUNT=4, DECAY_STEP=64)
REQ-025 Reset then pass-through: hold rst=0 for 3 cycles, release, fadeEn=0, dataIn=8'h81 -> ledOut=8'h00 during reset, then 8'h81 from the 2nd edge after dataIn is applied.
REQ-026 Decay sequence: fadeEn=1, pulse dataIn=8'h01 for 1 cycle, then 0 -> level[0] follows 255,191,127,63,0, changing only on decay ticks (every 4 cycles), and stays at 0.
REQ-027 Duty measurement: hold level[0] at 191 -> ledOut[0] is high for exactly 191 of 255 consecutive cycles, at pwmCnt values 0 to 190.
REQ-028 Load beats decay: assert dataIn[3]=1 on a decay-tick cycle while level[3]=127 -> level[3]=255 on the next cycle.
REQ-029 Rotating input: drive dataIn with 8'h80, 8'h40, 8'h20, ... for 8 cycles each, fadeEn=1 -> the current channel is at 255 and earlier channels show strictly decreasing non-zero levels until they saturate at 0.
REQ-030 Reset mid-fade: assert rst=0 while level[5]=127 and pwmCnt=100 -> all levels, pwmCnt, the timer and ledOut are 0 on the next edge, and pwmCnt restarts at 0 after release.
